// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port, fixed-latency memory between the instruction fetch
// port (IF, read-only) and the load/store port (D). Each side presents a
// req/ready handshake; when both request in the same IDLE cycle the port that
// did not win last time is granted (round-robin over two requesters).
//
// Every access runs the same sequence:
//   IDLE  -> accept one request (combinational ready)
//   ISSUE -> mem_en pulses with the registered address / we / wdata
//   WAIT  -> MEM_LAT cycles; mem_rdata is captured in the last one
//   RESP  -> the winning port sees a one-cycle rvalid
// busy is high in every state other than IDLE so the core can stall.
//
// Parameters
//   ADDR_W   address width (byte address passed through unchanged)
//   DATA_W   data width
//   MEM_LAT  cycles from the mem_en cycle to valid mem_rdata, >= 1
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   if_req/if_addr             fetch request and address
//   if_ready                   fetch grant (accept = if_req & if_ready)
//   if_rvalid/if_rdata         fetch response pulse, data held until next one
//   d_req/d_we/d_addr/d_wdata  load/store request
//   d_ready                    data grant (accept = d_req & d_ready)
//   d_rvalid/d_rdata           load data or store completion; d_rdata only
//                              changes on loads
//   mem_en/mem_we/mem_addr/    memory command; mem_en is the only qualifier,
//   mem_wdata                  the other fields hold their last value
//   mem_rdata                  memory read data, MEM_LAT cycles after mem_en
//   busy                       arbiter is sequencing an access
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,

  // Instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  // Load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  // Memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } grant_t;

  // The wait counter runs MEM_LAT-1 down to 0, so it only needs to hold
  // MEM_LAT-1; keep at least one bit for MEM_LAT == 1.
  localparam int                CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           state;
  state_t           state_next;
  grant_t           last_grant;
  logic             cur_is_d;     // owner of the access in flight
  logic [CNT_W-1:0] wait_cnt;

  logic             if_acc;
  logic             d_acc;
  logic             wait_done;

  assign if_acc    = if_req & if_ready;
  assign d_acc     = d_req & d_ready;
  assign wait_done = (state == S_WAIT) && (wait_cnt == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so that all
  // registers sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next is given a default before the case so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (if_acc || d_acc) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    mem_en    = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    busy      = (state != S_IDLE);

    unique case (state)
      S_IDLE: begin
        // A lone requester always wins; on contention the side that was not
        // granted last time goes first.
        if_ready = if_req & (~d_req | (last_grant == GNT_D));
        d_ready  = d_req  & (~if_req | (last_grant == GNT_IF));
      end
      S_ISSUE: mem_en = 1'b1;
      S_RESP: begin
        if_rvalid = ~cur_is_d;
        d_rvalid  = cur_is_d;
      end
      default: ;
    endcase

    // The grants are purely combinational from the requests, so hold them
    // low while reset is asserted to keep every output at 0 during reset.
    if (!reset) begin
      if_ready = 1'b0;
      d_ready  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant history, command registers and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GNT_IF;
      cur_is_d   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wait_cnt   <= '0;
    end else begin
      if (if_acc || d_acc) begin
        last_grant <= d_acc ? GNT_D : GNT_IF;
        cur_is_d   <= d_acc;
        mem_addr   <= d_acc ? d_addr : if_addr;
        // Fetches are never writes.
        mem_we     <= d_acc & d_we;
        if (d_acc) begin
          mem_wdata <= d_wdata;
        end
      end

      if (state == S_ISSUE) begin
        wait_cnt <= CNT_LOAD;
      end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response data: captured in the last WAIT cycle so it is visible together
  // with rvalid in RESP, and held until the same port's next read returns.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (wait_done) begin
      if (!cur_is_d) begin
        if_rdata <= mem_rdata;
      end else if (!mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Two arbiter instances: "a" with MEM_LAT=2 for most scenarios and "b" with
// MEM_LAT=1 for the short-latency case. Each has a behavioural memory that
// returns addr ^ 0xA5A5 exactly MEM_LAT cycles after mem_en (garbage
// otherwise). Stimulus pushes expected responses into a per-instance queue;
// a monitor on the falling edge pops and compares them on every rvalid.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [DW-1:0] GARBAGE = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          is_d;
    logic          is_wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // ---------------- instance a (MEM_LAT = 2) ----------------
  logic          a_if_req = 1'b0, a_d_req = 1'b0, a_d_we = 1'b0;
  logic [AW-1:0] a_if_addr = '0, a_d_addr = '0;
  logic [DW-1:0] a_d_wdata = '0;
  logic          a_if_ready, a_if_rvalid, a_d_ready, a_d_rvalid;
  logic [DW-1:0] a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0] a_mem_addr;
  logic          a_mem_en, a_mem_we, a_busy;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) u_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ready(a_if_ready),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ready(a_d_ready), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  logic [DW-1:0] a_pipe0 = '0, a_pipe1 = '0;
  int            a_en_cnt = 0;
  always @(posedge clk) begin
    a_pipe0 <= a_mem_en ? (a_mem_addr ^ 64'hA5A5) : GARBAGE;
    a_pipe1 <= a_pipe0;
    if (a_mem_en) a_en_cnt <= a_en_cnt + 1;
  end
  assign a_mem_rdata = a_pipe1;

  // ---------------- instance b (MEM_LAT = 1) ----------------
  logic          b_if_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
  logic [AW-1:0] b_if_addr = '0, b_d_addr = '0;
  logic [DW-1:0] b_d_wdata = '0;
  logic          b_if_ready, b_if_rvalid, b_d_ready, b_d_rvalid;
  logic [DW-1:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic          b_mem_en, b_mem_we, b_busy;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  logic [DW-1:0] b_pipe0 = '0;
  always @(posedge clk) begin
    b_pipe0 <= b_mem_en ? (b_mem_addr ^ 64'hA5A5) : GARBAGE;
  end
  assign b_mem_rdata = b_pipe0;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic is_d, input logic is_wr, input logic [DW-1:0] data);
    exp_t e;
    e.is_d  = is_d;
    e.is_wr = is_wr;
    e.data  = data;
    return e;
  endfunction

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- response monitors ----------------
  logic [DW-1:0] held_if_a = '0, held_d_a = '0;
  logic [DW-1:0] held_if_b = '0, held_d_b = '0;

  always @(negedge clk) begin
    if (!reset) begin
      q_a.delete();
      held_if_a = '0;
      held_d_a  = '0;
    end else begin
      check("a_ready_exclusive", a_if_ready & a_d_ready, 0);
      check("a_rvalid_exclusive", a_if_rvalid & a_d_rvalid, 0);
      if (a_if_rvalid || a_d_rvalid) begin
        check("a_rsp_expected", (q_a.size() > 0), 1);
        if (q_a.size() > 0) begin
          exp_t e;
          e = q_a.pop_front();
          check("a_rsp_port", a_d_rvalid, e.is_d);
          if (!e.is_d)        held_if_a = e.data;
          else if (!e.is_wr)  held_d_a  = e.data;
          check("a_if_rdata", a_if_rdata, held_if_a);
          check("a_d_rdata", a_d_rdata, held_d_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      q_b.delete();
      held_if_b = '0;
      held_d_b  = '0;
    end else begin
      check("b_ready_exclusive", b_if_ready & b_d_ready, 0);
      if (b_if_rvalid || b_d_rvalid) begin
        check("b_rsp_expected", (q_b.size() > 0), 1);
        if (q_b.size() > 0) begin
          exp_t e;
          e = q_b.pop_front();
          check("b_rsp_port", b_d_rvalid, e.is_d);
          if (!e.is_d)        held_if_b = e.data;
          else if (!e.is_wr)  held_d_b  = e.data;
          check("b_if_rdata", b_if_rdata, held_if_b);
          check("b_d_rdata", b_d_rdata, held_d_b);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int en0;

    // Reset state
    @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_mem_en", a_mem_en, 0);
    check("rst_mem_addr", a_mem_addr, 0);
    check("rst_if_rdata", a_if_rdata, 0);
    check("rst_b_busy", b_busy, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1. Single fetch: response four cycles after accept
    tick();
    a_if_req  = 1'b1;
    a_if_addr = 64'h10;
    q_a.push_back(mk(1'b0, 1'b0, 64'h10 ^ 64'hA5A5));
    @(negedge clk);
    check("t1_if_ready", a_if_ready, 1);
    check("t1_busy_c0", a_busy, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) a_if_req = 1'b0;
      @(negedge clk);
      check("t1_busy", a_busy, (c <= 4));
      check("t1_mem_en", a_mem_en, (c == 1));
      check("t1_if_rvalid", a_if_rvalid, (c == 4));
      if (c == 1) begin
        check("t1_mem_addr", a_mem_addr, 64'h10);
        check("t1_mem_we", a_mem_we, 0);
      end
    end

    // 2. Contention: D, IF, D, IF at cycles 0, 5, 10, 15
    en0 = a_en_cnt;
    for (int c = 0; c <= 19; c++) begin
      tick();
      if (c == 0) begin
        a_if_req  = 1'b1;
        a_if_addr = 64'h100;
        a_d_req   = 1'b1;
        a_d_we    = 1'b0;
        a_d_addr  = 64'h200;
        q_a.push_back(mk(1'b1, 1'b0, 64'h200 ^ 64'hA5A5));
        q_a.push_back(mk(1'b0, 1'b0, 64'h100 ^ 64'hA5A5));
        q_a.push_back(mk(1'b1, 1'b0, 64'h200 ^ 64'hA5A5));
        q_a.push_back(mk(1'b0, 1'b0, 64'h100 ^ 64'hA5A5));
      end
      if (c == 16) begin
        a_if_req = 1'b0;
        a_d_req  = 1'b0;
      end
      @(negedge clk);
      check("t2_d_ready", a_d_ready, (c == 0 || c == 10));
      check("t2_if_ready", a_if_ready, (c == 5 || c == 15));
    end
    tick();
    tick();
    check("t2_mem_en_count", a_en_cnt - en0, 4);

    // 3. Store: completion pulse, d_rdata keeps the last load value
    tick();
    a_d_req   = 1'b1;
    a_d_we    = 1'b1;
    a_d_addr  = 64'h8;
    a_d_wdata = 64'hDEAD;
    q_a.push_back(mk(1'b1, 1'b1, '0));
    @(negedge clk);
    check("t3_d_ready", a_d_ready, 1);
    check("t3_if_ready", a_if_ready, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        a_d_req = 1'b0;
        a_d_we  = 1'b0;
      end
      @(negedge clk);
      check("t3_mem_en", a_mem_en, (c == 1));
      check("t3_d_rvalid", a_d_rvalid, (c == 4));
      check("t3_if_rvalid", a_if_rvalid, 0);
      if (c == 1) begin
        check("t3_mem_we", a_mem_we, 1);
        check("t3_mem_wdata", a_mem_wdata, 64'hDEAD);
        check("t3_mem_addr", a_mem_addr, 64'h8);
      end
    end

    // 4. Request pulsed while busy is ignored
    en0 = a_en_cnt;
    tick();
    a_if_req  = 1'b1;
    a_if_addr = 64'h30;
    q_a.push_back(mk(1'b0, 1'b0, 64'h30 ^ 64'hA5A5));
    @(negedge clk);
    check("t4_if_ready", a_if_ready, 1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) a_if_req = 1'b0;
      if (c == 2) begin
        a_d_req  = 1'b1;
        a_d_addr = 64'h40;
      end
      if (c == 3) a_d_req = 1'b0;
      @(negedge clk);
      check("t4_d_ready", a_d_ready, 0);
      check("t4_if_rvalid", a_if_rvalid, (c == 4));
    end
    tick();
    check("t4_mem_en_count", a_en_cnt - en0, 1);

    // 5. Reset in WAIT: outputs clear at once, no response, D wins afterwards
    tick();
    a_d_req  = 1'b1;
    a_d_we   = 1'b0;
    a_d_addr = 64'h50;
    @(negedge clk);
    check("t5_d_ready", a_d_ready, 1);
    tick();
    a_d_req = 1'b0;
    tick();
    reset    = 1'b0;
    a_if_req = 1'b1;
    a_d_req  = 1'b1;
    #1;
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_mem_en", a_mem_en, 0);
    check("t5_rst_mem_we", a_mem_we, 0);
    check("t5_rst_mem_addr", a_mem_addr, 0);
    check("t5_rst_mem_wdata", a_mem_wdata, 0);
    check("t5_rst_if_ready", a_if_ready, 0);
    check("t5_rst_d_ready", a_d_ready, 0);
    check("t5_rst_if_rvalid", a_if_rvalid, 0);
    check("t5_rst_d_rvalid", a_d_rvalid, 0);
    check("t5_rst_if_rdata", a_if_rdata, 0);
    check("t5_rst_d_rdata", a_d_rdata, 0);
    repeat (2) begin
      @(negedge clk);
      check("t5_rst_no_rvalid", a_if_rvalid | a_d_rvalid, 0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    q_a.push_back(mk(1'b1, 1'b0, 64'h50 ^ 64'hA5A5));
    @(negedge clk);
    check("t5_post_d_ready", a_d_ready, 1);
    check("t5_post_if_ready", a_if_ready, 0);
    tick();
    a_if_req = 1'b0;
    a_d_req  = 1'b0;
    repeat (5) tick();

    // 6. MEM_LAT=1: response at cycle 3, accepts every 4 cycles
    for (int c = 0; c <= 12; c++) begin
      tick();
      if (c == 0) begin
        b_if_req  = 1'b1;
        b_if_addr = 64'h60;
        repeat (3) q_b.push_back(mk(1'b0, 1'b0, 64'h60 ^ 64'hA5A5));
      end
      if (c == 9) b_if_req = 1'b0;
      @(negedge clk);
      check("t6_if_ready", b_if_ready, ((c % 4) == 0) && (c <= 8));
      check("t6_mem_en", b_mem_en, ((c % 4) == 1) && (c <= 9));
      check("t6_if_rvalid", b_if_rvalid, ((c % 4) == 3) && (c <= 11));
    end

    tick();
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
